// File: rtl/adiabatic_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// adiabatic_phase_sequencer_if
//   Operation issue / result handshake between the ALU issue logic and the
//   adiabatic phase sequencer.
//
//   op_valid   issue -> seq   operation request
//   op_ready   seq -> issue   sequencer can accept an op this cycle
//   op_id      issue -> seq   tag of the requested op
//   res_valid  seq -> issue   1-cycle pulse, last gate stage holds its result
//   res_id     seq -> issue   tag of the completing op, valid with res_valid
//
//   master: issue side.  slave: sequencer side.
// ----------------------------------------------------------------------------
interface adiabatic_phase_sequencer_if #(
    parameter int ID_W = 4
) ();
    logic            op_valid;
    logic            op_ready;
    logic [ID_W-1:0] op_id;
    logic            res_valid;
    logic [ID_W-1:0] res_id;

    modport master (
        output op_valid,
        output op_id,
        input  op_ready,
        input  res_valid,
        input  res_id
    );

    modport slave (
        input  op_valid,
        input  op_id,
        output op_ready,
        output res_valid,
        output res_id
    );
endinterface

// File: rtl/adiabatic_phase_sequencer.sv
// ----------------------------------------------------------------------------
// adiabatic_phase_sequencer
//   Sequences the 4-phase stepwise power clocks (clkpos/clkneg level pairs)
//   for the adiabatic ALU gate pipeline.  An accepted op starts a run in which
//   each phase ramps RISE/HOLD/FALL/IDLE, one segment of STEPS clocks each,
//   phase k lagging phase 0 by k segments.  res_valid pulses with the op tag
//   when the last gate stage holds its evaluated output (launch + L clocks).
//
// Ports
//   clk       sequencer clock
//   rst_n     asynchronous reset, active low
//   bus       op/result handshake (slave modport)
//   phi_lvl   per-phase clkpos step level, phase k at [k*LVL_W +: LVL_W]
//   phi_lvln  per-phase clkneg level, STEPS - phi_lvl per phase
//   busy      sequencer is not idle
//
// Build option
//   ADB_BURST_EN  when defined, a further op may be accepted in RUN on the
//                 phase-0 launch slot (tick == PER-1); up to
//                 ceil((L+1)/PER) ops are tracked in flight.  When undefined
//                 only one op is in flight and op_ready is asserted in IDLE.
//
// State table
//   state  | meaning
//   IDLE   | no ramps, tick held 0, ready for an op
//   RUN    | ops in flight, phases re-arm their mask on each RISE entry
//   DRAIN  | no ops left, ramps finish, phases drop out at their next RISE
// ----------------------------------------------------------------------------
module adiabatic_phase_sequencer #(
    parameter int  STEPS = 4,
    parameter int  DEPTH = 4,
    parameter int  ID_W  = 4,
    localparam int NPH   = 4,
    localparam int LVL_W = $clog2(STEPS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    adiabatic_phase_sequencer_if.slave bus,
    output logic [NPH*LVL_W-1:0]       phi_lvl,
    output logic [NPH*LVL_W-1:0]       phi_lvln,
    output logic                       busy
);

    localparam int PER    = NPH * STEPS;
    localparam int L      = (DEPTH + 1) * STEPS - 1;
    localparam int TICK_W = $clog2(PER);
    localparam int CNT_W  = $clog2(L + 1);
`ifdef ADB_BURST_EN
    localparam int NSLOT  = (L + PER) / PER;
`else
    localparam int NSLOT  = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [TICK_W-1:0]      tick, tick_nx, tick_inc;
    logic [NPH-1:0]         mask, mask_nx;
    logic [NSLOT-1:0]       act, act_nx;
    logic [CNT_W-1:0]       cnt    [NSLOT];
    logic [CNT_W-1:0]       cnt_nx [NSLOT];
    logic [ID_W-1:0]        tag    [NSLOT];
    logic [ID_W-1:0]        tag_nx [NSLOT];
    logic [NPH*LVL_W-1:0]   lvl_nx, lvln_nx;
    logic                   res_valid_q, res_valid_nx;
    logic [ID_W-1:0]        res_id_q, res_id_nx;
    logic                   op_ready_q, op_ready_nx;
    logic                   accept;
    logic                   placed;

    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;

    assign accept   = bus.op_valid && op_ready_q;
    assign tick_inc = (tick == TICK_W'(PER - 1)) ? '0 : tick + TICK_W'(1);

    // Level of phase k at tick t, ignoring its mask.
    function automatic logic [LVL_W-1:0] ramp_lvl(input logic [TICK_W-1:0] t,
                                                   input logic [1:0]        k);
        logic [1:0]       seg;
        logic [LVL_W-1:0] s;
        seg = 2'(t / TICK_W'(STEPS)) - k;
        s   = LVL_W'(t % TICK_W'(STEPS));
        case (seg)
            2'd0:    ramp_lvl = s + LVL_W'(1);
            2'd1:    ramp_lvl = LVL_W'(STEPS);
            2'd2:    ramp_lvl = LVL_W'(STEPS - 1) - s;
            default: ramp_lvl = '0;
        endcase
    endfunction

    always_comb begin
        state_nx     = state;
        tick_nx      = tick;
        mask_nx      = mask;
        act_nx       = act;
        cnt_nx       = cnt;
        tag_nx       = tag;
        res_valid_nx = 1'b0;
        res_id_nx    = res_id_q;
        placed       = 1'b0;
        lvl_nx       = '0;
        lvln_nx      = '0;
        op_ready_nx  = 1'b0;

        // In-flight countdowns; terminal count fires the result next cycle.
        for (int i = 0; i < NSLOT; i++) begin
            if (act[i]) begin
                if (cnt[i] == '0) begin
                    act_nx[i]    = 1'b0;
                    res_valid_nx = 1'b1;
                    res_id_nx    = tag[i];
                end else begin
                    cnt_nx[i] = cnt[i] - CNT_W'(1);
                end
            end
        end

        // Launch is the cycle after accept, so L-1 here lands the pulse at A+1+L.
        if (accept) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (!placed && !act_nx[i]) begin
                    act_nx[i] = 1'b1;
                    cnt_nx[i] = CNT_W'(L - 1);
                    tag_nx[i] = bus.op_id;
                    placed    = 1'b1;
                end
            end
        end

        case (state)
            S_IDLE: begin
                tick_nx = '0;
                if (accept) state_nx = S_RUN;
            end
            S_RUN: begin
                tick_nx = tick_inc;
                if (res_valid_q && (act == '0) && !accept) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                tick_nx = tick_inc;
            end
            default: begin
                state_nx = S_IDLE;
                tick_nx  = '0;
            end
        endcase

        // A phase's mask is only rewritten on the cycle it enters RISE.
        if (state_nx == S_IDLE) begin
            mask_nx = '0;
        end else begin
            for (int k = 0; k < NPH; k++) begin
                if (tick_nx == TICK_W'(k * STEPS)) mask_nx[k] = (state_nx == S_RUN);
            end
        end

        if ((state_nx == S_DRAIN) && (mask_nx == '0)) begin
            state_nx = S_IDLE;
            tick_nx  = '0;
        end

        for (int k = 0; k < NPH; k++) begin
            lvl_nx[k*LVL_W +: LVL_W]  = mask_nx[k] ? ramp_lvl(tick_nx, 2'(k)) : '0;
            lvln_nx[k*LVL_W +: LVL_W] = LVL_W'(STEPS) - lvl_nx[k*LVL_W +: LVL_W];
        end

        op_ready_nx = (state_nx == S_IDLE);
`ifdef ADB_BURST_EN
        if ((state_nx == S_RUN) && (tick_nx == TICK_W'(PER - 1)) && (act_nx != '1))
            op_ready_nx = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tick        <= '0;
            mask        <= '0;
            act         <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                cnt[i] <= '0;
                tag[i] <= '0;
            end
            phi_lvl     <= '0;
            phi_lvln    <= {NPH{LVL_W'(STEPS)}};
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            op_ready_q  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            tick        <= tick_nx;
            mask        <= mask_nx;
            act         <= act_nx;
            cnt         <= cnt_nx;
            tag         <= tag_nx;
            phi_lvl     <= lvl_nx;
            phi_lvln    <= lvln_nx;
            res_valid_q <= res_valid_nx;
            res_id_q    <= res_id_nx;
            op_ready_q  <= op_ready_nx;
            busy        <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_adiabatic_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adiabatic_phase_sequencer
//   Self-checking bench.  Expected ramps are computed from run timing: each
//   phase k rises at run_start + k*STEPS + m*PER for every such slot that
//   falls before the drain point, and follows the RISE/HOLD/FALL profile from
//   its most recent rise.  Cycle numbers inside a test are relative to the
//   accept cycle (c = 0).
// ----------------------------------------------------------------------------
module tb_adiabatic_phase_sequencer;

    localparam int STEPS = 4;
    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int NPH   = 4;
    localparam int LVL_W = 3;
    localparam int PER   = NPH * STEPS;
    localparam int LAT   = (DEPTH + 1) * STEPS - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adiabatic_phase_sequencer_if #(.ID_W(ID_W)) bus ();
    logic [NPH*LVL_W-1:0] phi_lvl;
    logic [NPH*LVL_W-1:0] phi_lvln;
    logic                 busy;

    adiabatic_phase_sequencer #(.STEPS(STEPS), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .phi_lvl  (phi_lvl),
        .phi_lvln (phi_lvln),
        .busy     (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Ramp profile d clocks after a RISE entry.
    function automatic int ramp_at(int d);
        if (d < 0)         return 0;
        if (d < STEPS)     return d + 1;
        if (d < 2 * STEPS) return STEPS;
        if (d < 3 * STEPS) return 3 * STEPS - 1 - d;
        return 0;
    endfunction

    // Phase k level at cycle c for a run starting at r that drains from e.
    function automatic int exp_lvl(int k, int c, int r, int e);
        int last;
        last = -1;
        for (int t = r + k * STEPS; t <= c && t < e; t += PER) last = t;
        if (last < 0) return 0;
        return ramp_at(c - last);
    endfunction

    // Every phase drops out at one blocked rise slot; IDLE at the fourth.
    function automatic int idle_at(int r, int e);
        int j;
        j = (e - r + STEPS - 1) / STEPS;
        return r + (j + 3) * STEPS;
    endfunction

    function automatic logic [NPH*LVL_W-1:0] exp_vec(int c, int r, int e, bit neg);
        logic [NPH*LVL_W-1:0] v;
        v = '0;
        for (int k = 0; k < NPH; k++) begin
            if (neg) v[k*LVL_W +: LVL_W] = LVL_W'(STEPS - exp_lvl(k, c, r, e));
            else     v[k*LVL_W +: LVL_W] = LVL_W'(exp_lvl(k, c, r, e));
        end
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.op_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_ready op_ready=%b required=1", bus.op_ready);
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        bus.op_valid = 1'b0;
        bus.op_id    = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (phi_lvl !== '0) begin failures++; $display("FAIL rst_phi_lvl got=%h exp=000", phi_lvl); end
        if (phi_lvln !== 12'h924) begin failures++; $display("FAIL rst_phi_lvln got=%h exp=924", phi_lvln); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
        if (bus.res_id !== '0) begin failures++; $display("FAIL rst_res_id got=%h exp=0", bus.res_id); end
        if (bus.op_ready !== 1'b0) begin failures++; $display("FAIL rst_op_ready got=%b exp=0", bus.op_ready); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", bus.op_ready); end

        // Abort an op at a random point mid-run.
        wait_ready(ok);
        if (!ok) return;
        bus.op_valid = 1'b1;
        bus.op_id    = ID_W'($urandom);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat ($urandom_range(2, 18)) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        checks += 3;
        if (phi_lvl !== '0) begin failures++; $display("FAIL abort_phi_lvl got=%h exp=000", phi_lvl); end
        if (phi_lvln !== 12'h924) begin failures++; $display("FAIL abort_phi_lvln got=%h exp=924", phi_lvln); end
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b0 || busy !== 1'b0 || phi_lvl !== '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL abort_quiet activity_seen=1 required=0"); end
    endtask

    task automatic test_single(input logic [ID_W-1:0] id);
        bit ok;
        int e, idle, cur, rises;
        int prev [NPH];
        bit jump, exp_rdy;
        wait_ready(ok);
        if (!ok) return;
        bus.op_valid = 1'b1;
        bus.op_id    = id;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        e    = LAT + 2;
        idle = idle_at(1, e);
        for (int k = 0; k < NPH; k++) prev[k] = 0;
        for (int c = 1; c <= idle; c++) begin
            checks += 8;
            if (phi_lvl !== exp_vec(c, 1, e, 1'b0)) begin
                failures++; $display("FAIL lvl c=%0d got=%h exp=%h", c, phi_lvl, exp_vec(c, 1, e, 1'b0));
            end
            if (phi_lvln !== exp_vec(c, 1, e, 1'b1)) begin
                failures++; $display("FAIL lvln c=%0d got=%h exp=%h", c, phi_lvln, exp_vec(c, 1, e, 1'b1));
            end
            if (bus.res_valid !== (c == LAT + 1)) begin
                failures++; $display("FAIL res_valid c=%0d got=%b exp=%b", c, bus.res_valid, c == LAT + 1);
            end
            if (c == LAT + 1 && bus.res_id !== id) begin
                failures++; $display("FAIL res_id got=%h exp=%h", bus.res_id, id);
            end
            if (busy !== (c < idle)) begin
                failures++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, c < idle);
            end
            exp_rdy = (c >= idle);
`ifdef ADB_BURST_EN
            if (c < e && (c - 1) % PER == PER - 1) exp_rdy = 1'b1;
`endif
            if (bus.op_ready !== exp_rdy) begin
                failures++; $display("FAIL op_ready c=%0d got=%b exp=%b", c, bus.op_ready, exp_rdy);
            end
            rises = 0;
            jump  = 1'b0;
            for (int k = 0; k < NPH; k++) begin
                cur = int'(phi_lvl[k*LVL_W +: LVL_W]);
                if (cur > prev[k]) rises++;
                if (cur - prev[k] > 1 || prev[k] - cur > 1) jump = 1'b1;
                prev[k] = cur;
            end
            if (rises > 1) begin failures++; $display("FAIL one_rise c=%0d got=%0d exp<=1", c, rises); end
            if (jump) begin failures++; $display("FAIL no_jump c=%0d got=jump exp=step<=1", c); end
            if (c < idle) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            test_single(ID_W'($urandom));
        end
    endtask

`ifdef ADB_BURST_EN
    task automatic test_burst();
        bit ok, exp_rdy;
        int e, idle, t1, t2;
        wait_ready(ok);
        if (!ok) return;
        bus.op_valid = 1'b1;
        bus.op_id    = 4'h1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        e    = PER + LAT + 2;
        idle = idle_at(1, e);
        t1   = -1;
        t2   = -1;
        for (int c = 1; c <= idle; c++) begin
            checks += 4;
            if (phi_lvl !== exp_vec(c, 1, e, 1'b0)) begin
                failures++; $display("FAIL burst_lvl c=%0d got=%h exp=%h", c, phi_lvl, exp_vec(c, 1, e, 1'b0));
            end
            exp_rdy = (c >= idle) || (c < e && (c - 1) % PER == PER - 1);
            if (bus.op_ready !== exp_rdy) begin
                failures++; $display("FAIL burst_ready c=%0d got=%b exp=%b", c, bus.op_ready, exp_rdy);
            end
            if (bus.res_valid !== (c == LAT + 1 || c == LAT + 1 + PER)) begin
                failures++; $display("FAIL burst_res_valid c=%0d got=%b", c, bus.res_valid);
            end
            if (busy !== (c < idle)) begin
                failures++; $display("FAIL burst_busy c=%0d got=%b exp=%b", c, busy, c < idle);
            end
            if (bus.res_valid === 1'b1) begin
                checks++;
                if (t1 < 0) begin
                    t1 = c;
                    if (bus.res_id !== 4'h1) begin failures++; $display("FAIL burst_id1 got=%h exp=1", bus.res_id); end
                end else begin
                    t2 = c;
                    if (bus.res_id !== 4'h2) begin failures++; $display("FAIL burst_id2 got=%h exp=2", bus.res_id); end
                end
            end
            if (c == PER && bus.op_ready === 1'b1) begin
                bus.op_valid = 1'b1;
                bus.op_id    = 4'h2;
            end else begin
                bus.op_valid = 1'b0;
            end
            if (c < idle) begin
                @(posedge clk); #1;
            end
        end
        bus.op_valid = 1'b0;
        checks++;
        if (t2 - t1 != PER) begin failures++; $display("FAIL burst_gap got=%0d exp=%0d", t2 - t1, PER); end
    endtask
`else
    task automatic test_backpressure();
        bit ok;
        int e, idle, idle2;
        logic [ID_W-1:0] x, y;
        x = ID_W'($urandom);
        y = ~x;
        wait_ready(ok);
        if (!ok) return;
        bus.op_valid = 1'b1;
        bus.op_id    = x;
        @(posedge clk); #1;
        bus.op_id    = y;
        e    = LAT + 2;
        idle = idle_at(1, e);
        for (int c = 1; c <= idle; c++) begin
            checks += 3;
            if (bus.op_ready !== (c >= idle)) begin
                failures++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.op_ready, c >= idle);
            end
            if (bus.res_valid !== (c == LAT + 1)) begin
                failures++; $display("FAIL bp_res_valid c=%0d got=%b exp=%b", c, bus.res_valid, c == LAT + 1);
            end
            if (phi_lvl !== exp_vec(c, 1, e, 1'b0)) begin
                failures++; $display("FAIL bp_lvl c=%0d got=%h exp=%h", c, phi_lvl, exp_vec(c, 1, e, 1'b0));
            end
            if (c == LAT + 1) begin
                checks++;
                if (bus.res_id !== x) begin failures++; $display("FAIL bp_id1 got=%h exp=%h", bus.res_id, x); end
            end
            if (c < idle) begin
                @(posedge clk); #1;
            end
        end
        // The held request is taken on the first IDLE cycle.
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        idle2 = idle_at(idle + 1, idle + LAT + 2);
        for (int c = idle + 1; c <= idle2; c++) begin
            checks += 3;
            if (bus.res_valid !== (c == idle + LAT + 1)) begin
                failures++; $display("FAIL bp_res2 c=%0d got=%b exp=%b", c, bus.res_valid, c == idle + LAT + 1);
            end
            if (busy !== (c < idle2)) begin
                failures++; $display("FAIL bp_busy2 c=%0d got=%b exp=%b", c, busy, c < idle2);
            end
            if (phi_lvl !== exp_vec(c, idle + 1, idle + LAT + 2, 1'b0)) begin
                failures++; $display("FAIL bp_lvl2 c=%0d got=%h", c, phi_lvl);
            end
            if (c == idle + LAT + 1) begin
                checks++;
                if (bus.res_id !== y) begin failures++; $display("FAIL bp_id2 got=%h exp=%h", bus.res_id, y); end
            end
            if (c < idle2) begin
                @(posedge clk); #1;
            end
        end
    endtask
`endif

    initial begin
        bus.op_valid = 1'b0;
        bus.op_id    = '0;
        test_reset();
        test_single(4'h5);
        test_back_to_back();
`ifdef ADB_BURST_EN
        test_burst();
`else
        test_backpressure();
`endif
        test_reset();
        test_single(ID_W'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached=1 required=0");
        $fatal(1, "watchdog");
    end

endmodule
